demux_1_n_stream: RTL and testbench
===================================

# demux_1_n_stream

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output. It generalises the combinational 1-to-8 demux to configurable data width and channel count. Each output gets a one-entry holding buffer, so a stalled output never corrupts data and never blocks beats aimed at other channels. It sits between a single producer and N independent consumers; out-of-range selects are dropped and counted.

## Interface
- W, 8, data width in bits (≥1)
- N, 8, number of output channels (2..256)
- SW, $clog2(N), select width (derived, not overridden)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid=1
- in_data  input  W  input payload
- sel  input  SW  destination channel, sampled with in_data
- bcast  input  1  broadcast request (active only with DEMUX_BCAST_EN)
- out_valid  output  N  per-channel buffer holds a beat
- out_ready  input  N  per-channel consumer accepts
- out_data  output  N*W  channel k payload at bits [k*W +: W]
- drop_cnt  output  8  saturating count of dropped out-of-range beats

## Operation
- Per channel k: buffer valid bit v[k] and data register d[k]; out_valid[k]=v[k], out_data slice k = d[k].
- Channel k can load when !v[k] || out_ready[k].
- Normal beat (bcast=0 or macro off), sel<N: in_ready = load-able(sel). On in_valid && in_ready: d[sel]<=in_data, v[sel]<=1.
- sel≥N (only possible when N not a power of two): in_ready=1, beat discarded, drop_cnt increments, saturating at 255.
- Output drain: v[k] clears on out_valid[k] && out_ready[k] unless reloaded in the same cycle.
- Simultaneous drain and reload on the same channel: v[k] stays 1, d[k] takes new data, no bubble.
- Channels are independent. A full, stalled channel only back-pressures beats whose sel targets it.
- in_ready depends combinationally on sel, bcast and out_ready; there is no combinational path from in_valid to in_ready.
- No state machine beyond per-channel full/empty.
- Data is never duplicated, reordered within a channel, or lost except by out-of-range drop.

## Timing
- Reset (async assert, released synchronously to clk by the system): v=0, so out_valid=0; d=0, so out_data=0; drop_cnt=0.
- in_ready is combinational, so it can be high during reset.
- Latency: a beat accepted at edge t appears on out_valid/out_data after edge t, meaning it is visible in the cycle following acceptance.
- Throughput: 1 beat/cycle into any channel whose consumer holds out_ready=1.
- Reset mid-transfer: all buffered beats are discarded immediately and out_valid drops asynchronously.
- out_data slice k is stable while out_valid[k]=1 && out_ready[k]=0.

## Configuration
- DEMUX_BCAST_EN defined: when bcast=1, in_ready = AND over all k of load-able(k), and sel is ignored. On acceptance, every d[k] loads in_data and every v[k] is set. drop_cnt is unaffected.
- DEMUX_BCAST_EN undefined: bcast port is present but ignored, no broadcast logic is generated, and the block behaves exactly as with bcast=0.

## Test plan
- Sweep, W=8, N=8, all out_ready=1: in_data=8'hA0+k, sel=k for k=0..7 on consecutive cycles. Required: out_valid one-hot 8'b1<<k one cycle after each beat, slice k = A0+k, in_ready constantly 1.
- Stall: out_ready[3]=0, send two beats to sel=3 (8'h11, 8'h22). Required: first beat is held and in_ready=0 for the second. A beat to sel=5 during the stall is accepted. Releasing out_ready[3] drains 8'h11, then 8'h22 is accepted.
- Back-to-back reload: out_ready[2]=1, in_valid=1, sel=2 for 4 cycles with data 1,2,3,4. Required: out_valid[2]=1 continuously for 4 cycles, data 1,2,3,4.
- Drop, N=5: sel=6 for 300 beats. Required: in_ready=1, no out_valid, drop_cnt=255 (saturated).
- Reset mid-operation: assert rst while channels 0 and 7 hold data. Required: out_valid=0 and out_data=0 immediately, drop_cnt=0.
- With DEMUX_BCAST_EN: bcast=1, in_data=8'h5A, out_ready[4]=0 with channel 4 full. Required: in_ready=0. After channel 4 drains, the beat is accepted and all 8 outputs show 8'h5A next cycle.

Source files
------------

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with a one-entry buffer per output channel.
// Optional broadcast of one beat to every channel is built only when DEMUX_BCAST_EN is defined.
module demux_1_n_stream #(
    parameter  int W  = 8,
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [SW-1:0]    sel,
    input  logic             bcast,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [N*W-1:0]   out_data,
    output logic [7:0]       drop_cnt
);

    logic [N-1:0] r_v;
    logic [W-1:0] r_d [N];
    logic [7:0]   r_drop;

    logic [N-1:0] w_load;
    logic [N-1:0] w_sel_hot;
    logic [N-1:0] w_wr;
    logic         w_in_range;
    logic         w_bcast;
    logic         w_accept;
    logic         w_drop;

`ifdef DEMUX_BCAST_EN
    assign w_bcast = bcast;
`else
    logic w_unused_bcast;
    assign w_unused_bcast = bcast;
    assign w_bcast        = 1'b0;
`endif

    // A channel can take a new beat when empty or when its current beat leaves this cycle.
    assign w_load     = ~r_v | out_ready;
    assign w_in_range = (32'(sel) < 32'(N));

    always_comb begin
        w_sel_hot = '0;
        for (int k = 0; k < N; k++) begin
            w_sel_hot[k] = (32'(sel) == 32'(k));
        end
    end

    // Out-of-range selects are always accepted so they can be discarded.
    always_comb begin
        in_ready = 1'b1;
        if (w_bcast) begin
            in_ready = &w_load;
        end else if (w_in_range) begin
            in_ready = |(w_sel_hot & w_load);
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_wr     = w_accept ? (w_bcast ? {N{1'b1}} : w_sel_hot) : {N{1'b0}};
    assign w_drop   = w_accept & ~w_bcast & ~w_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < N; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_wr[k]) begin
                    r_v[k] <= 1'b1;
                    r_d[k] <= in_data;
                end else if (out_ready[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out_data[g*W +: W] = r_d[g];
    end

    assign out_valid = r_v;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: 8-channel instance with a per-channel queue scoreboard,
// plus a 5-channel instance for out-of-range drop counting.
module tb_demux_1_n_stream;

`ifdef DEMUX_BCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  sel;
    logic        bcast;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic [7:0]  drop_cnt;

    logic        d5_in_valid;
    logic        d5_in_ready;
    logic [7:0]  d5_in_data;
    logic [2:0]  d5_sel;
    logic [4:0]  d5_out_valid;
    logic [4:0]  d5_out_ready;
    logic [39:0] d5_out_data;
    logic [7:0]  d5_drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [8][$];
    logic [7:0] m_ld;
    logic       m_rdy;

    always #5 clk = ~clk;

    demux_1_n_stream #(.W(8), .N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sel(sel), .bcast(bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    demux_1_n_stream #(.W(8), .N(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(d5_in_valid), .in_ready(d5_in_ready), .in_data(d5_in_data),
        .sel(d5_sel), .bcast(1'b0),
        .out_valid(d5_out_valid), .out_ready(d5_out_ready), .out_data(d5_out_data),
        .drop_cnt(d5_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare buffered heads, pop on output handshake, push on modelled acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                m_ld[k] = (q[k].size() == 0) || out_ready[k];
                chk($sformatf("sb_valid%0d", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
                if (q[k].size() != 0) begin
                    chk($sformatf("sb_data%0d", k), 64'(out_data[k*8 +: 8]), 64'(q[k][0]));
                end
            end
            m_rdy = (BC && bcast) ? (&m_ld) : m_ld[sel];
            chk("sb_in_ready", 64'(in_ready), 64'(m_rdy));
            chk("sb_drop8", 64'(drop_cnt), 64'd0);
            for (int k = 0; k < 8; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    void'(q[k].pop_front());
                end
            end
            if (in_valid && m_rdy) begin
                if (BC && bcast) begin
                    for (int k = 0; k < 8; k++) q[k].push_back(in_data);
                end else begin
                    q[sel].push_back(in_data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; sel = '0; bcast = 1'b0; out_ready = 8'hFF;
        d5_in_valid = 1'b0; d5_in_data = '0; d5_sel = '0; d5_out_ready = 5'h1F;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Sweep all channels with every consumer ready
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; sel = 3'(k); in_data = 8'hA0 + 8'(k);
            #1 chk("sweep_rdy", 64'(in_ready), 64'd1);
            tick();
            chk("sweep_onehot", 64'(out_valid), 64'(8'd1 << k));
            chk("sweep_data", 64'(out_data[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
        end
        in_valid = 1'b0;
        tick();

        // Stall channel 3; channel 5 must stay reachable
        out_ready = 8'hF7;
        in_valid = 1'b1; sel = 3'd3; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        #1 chk("stall_rdy0", 64'(in_ready), 64'd0);
        tick();
        chk("stall_hold_v", 64'(out_valid[3]), 64'd1);
        chk("stall_hold_d", 64'(out_data[31:24]), 64'h11);
        sel = 3'd5; in_data = 8'h55;
        #1 chk("stall_other_rdy", 64'(in_ready), 64'd1);
        tick();
        chk("stall_other_v", 64'(out_valid[5]), 64'd1);
        chk("stall_other_d", 64'(out_data[47:40]), 64'h55);
        sel = 3'd3; in_data = 8'h22; out_ready = 8'hFF;
        #1 chk("stall_release_rdy", 64'(in_ready), 64'd1);
        tick();
        chk("stall_second_v", 64'(out_valid[3]), 64'd1);
        chk("stall_second_d", 64'(out_data[31:24]), 64'h22);
        in_valid = 1'b0;
        tick();

        // Back-to-back reload of channel 2 without bubbles
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; sel = 3'd2; in_data = 8'(i);
            tick();
            chk("reload_v", 64'(out_valid[2]), 64'd1);
            chk("reload_d", 64'(out_data[23:16]), 64'(i));
        end
        in_valid = 1'b0;
        tick();

        // Broadcast, or its absence
`ifdef DEMUX_BCAST_EN
        out_ready = 8'hEF;
        in_valid = 1'b1; sel = 3'd4; in_data = 8'h44;
        tick();
        bcast = 1'b1; sel = 3'd0; in_data = 8'h5A;
        #1 chk("bc_blocked", 64'(in_ready), 64'd0);
        tick();
        tick();
        chk("bc_still_blocked", 64'(in_ready), 64'd0);
        out_ready = 8'hFF;
        #1 chk("bc_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; bcast = 1'b0;
        chk("bc_all_valid", 64'(out_valid), 64'hFF);
        chk("bc_all_data", out_data, 64'h5A5A5A5A5A5A5A5A);
        tick();
`else
        bcast = 1'b1; in_valid = 1'b1; sel = 3'd1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0; bcast = 1'b0;
        chk("nobc_valid", 64'(out_valid), 64'h02);
        chk("nobc_data", 64'(out_data[15:8]), 64'h5A);
        tick();
`endif

        // Five-channel instance: in-range beat, then out-of-range drops
        d5_in_valid = 1'b1; d5_sel = 3'd4; d5_in_data = 8'h77;
        tick();
        chk("n5_valid", 64'(d5_out_valid), 64'h10);
        chk("n5_data", 64'(d5_out_data[39:32]), 64'h77);
        d5_sel = 3'd6;
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) begin
                #1 chk("drop_rdy", 64'(d5_in_ready), 64'd1);
            end
            tick();
            if (i % 50 == 0) chk("drop_no_valid", 64'(d5_out_valid), 64'd0);
            if (i == 199) chk("drop_200", 64'(d5_drop_cnt), 64'd200);
        end
        d5_in_valid = 1'b0;
        chk("drop_sat", 64'(d5_drop_cnt), 64'd255);

        // Reset while channels 0 and 7 hold data
        out_ready = 8'h7E;
        in_valid = 1'b1; sel = 3'd0; in_data = 8'hC0;
        tick();
        sel = 3'd7; in_data = 8'hC7;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'h81);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_drop5", 64'(d5_drop_cnt), 64'd0);
        for (int k = 0; k < 8; k++) q[k].delete();
        tick();
        tick();
        rst = 1'b0; out_ready = 8'hFF;
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
